// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the configuration frame loader.
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LD_WAIT  = 3'd1,
        ST_LD_WRITE = 3'd2,
        ST_RB_READ  = 3'd3,
        ST_RB_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    localparam logic OP_LOAD     = 1'b0;
    localparam logic OP_READBACK = 1'b1;

endpackage

// File: rtl/cfg_row_decoder.sv
// Registered one-hot row decode driving a true/complement wordline pair.
module cfg_row_decoder #(
    parameter int ROWS  = 16,
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [ROW_W-1:0] row_i,
    output logic [ROWS-1:0]  wl_o,
    output logic [ROWS-1:0]  wl_n_o
);

    logic [ROWS-1:0] wl_d, wl_q, wl_n_q;

    always_comb begin
        wl_d = '0;
        if (en_i) wl_d[row_i] = 1'b1;
    end

    // Both polarities come straight from flops so the pair never skews.
    always_ff @(posedge clk) begin
        if (reset) begin
            wl_q   <= '0;
            wl_n_q <= '1;
        end else begin
            wl_q   <= wl_d;
            wl_n_q <= ~wl_d;
        end
    end

    assign wl_o   = wl_q;
    assign wl_n_o = wl_n_q;

endmodule

// File: rtl/cfg_frame_loader.sv
// Row-by-row load/readback sequencer for one column-group of config SRAM cells.
module cfg_frame_loader
    import cfg_loader_pkg::*;
#(
    parameter int ROWS  = 16,
    parameter int COLS  = 8,
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_op,
    input  logic            in_valid,
    input  logic [COLS-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [COLS-1:0] out_data,
    input  logic            out_ready,
    output logic [ROWS-1:0] wl_write,
    output logic [ROWS-1:0] wl_writeN,
    output logic [ROWS-1:0] wl_read,
    output logic [ROWS-1:0] wl_readN,
    output logic [COLS-1:0] bit_write,
    input  logic [COLS-1:0] bit_read,
    output logic            busy,
    output logic            done
);

    state_e          state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COLS-1:0] bit_write_q, bit_write_d;
    logic [COLS-1:0] out_data_q, out_data_d;
    logic            cmd_ready_q, in_ready_q, out_valid_q, busy_q, done_q;
    logic            last_row;

    assign last_row = (row_q == ROW_W'(ROWS - 1));

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        bit_write_d = bit_write_q;
        out_data_d  = out_data_q;
        case (state_q)
            ST_IDLE: begin
                row_d = '0;
                if (cmd_valid)
                    state_d = (cmd_op == OP_READBACK) ? ST_RB_READ : ST_LD_WAIT;
            end
            ST_LD_WAIT: begin
                if (in_valid) begin
                    bit_write_d = in_data;
                    state_d     = ST_LD_WRITE;
                end
            end
            ST_LD_WRITE: begin
                if (last_row) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = ST_LD_WAIT;
                end
            end
            ST_RB_READ: begin
                out_data_d = bit_read;
                state_d    = ST_RB_HOLD;
            end
            ST_RB_HOLD: begin
                if (out_ready) begin
                    if (last_row) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = ST_RB_READ;
                    end
                end
            end
            ST_DONE: begin
                row_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            bit_write_q <= '0;
            out_data_q  <= '0;
            cmd_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            bit_write_q <= bit_write_d;
            out_data_q  <= out_data_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            in_ready_q  <= (state_d == ST_LD_WAIT);
            out_valid_q <= (state_d == ST_RB_HOLD);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    cfg_row_decoder #(.ROWS(ROWS), .ROW_W(ROW_W)) u_wr_dec (
        .clk    (clk),
        .reset  (reset),
        .en_i   (state_d == ST_LD_WRITE),
        .row_i  (row_d),
        .wl_o   (wl_write),
        .wl_n_o (wl_writeN)
    );

    cfg_row_decoder #(.ROWS(ROWS), .ROW_W(ROW_W)) u_rd_dec (
        .clk    (clk),
        .reset  (reset),
        .en_i   (state_d == ST_RB_READ),
        .row_i  (row_d),
        .wl_o   (wl_read),
        .wl_n_o (wl_readN)
    );

    assign cmd_ready = cmd_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign bit_write = bit_write_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed self-checking bench for cfg_frame_loader with a behavioural cell array.
module tb_cfg_frame_loader;

    localparam int ROWS = 16;
    localparam int COLS = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cmd_valid = 1'b0, cmd_op = 1'b0, cmd_ready;
    logic            in_valid = 1'b0, in_ready;
    logic [COLS-1:0] in_data = '0;
    logic            out_valid, out_ready = 1'b0;
    logic [COLS-1:0] out_data, bit_write, bit_read;
    logic [ROWS-1:0] wl_write, wl_writeN, wl_read, wl_readN;
    logic            busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    logic [COLS-1:0] mem [ROWS];

    cfg_frame_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .wl_write  (wl_write),
        .wl_writeN (wl_writeN),
        .wl_read   (wl_read),
        .wl_readN  (wl_readN),
        .bit_write (bit_write),
        .bit_read  (bit_read),
        .busy      (busy),
        .done      (done)
    );

    initial forever #5 clk = ~clk;

    // Cells capture on the edge that closes a write-wordline pulse.
    always @(posedge clk)
        for (int i = 0; i < ROWS; i++)
            if (wl_write[i]) mem[i] <= bit_write;

    // Undriven bus modelled as a fixed junk pattern.
    always_comb begin
        bit_read = 8'hA5;
        for (int i = 0; i < ROWS; i++)
            if (wl_read[i]) bit_read = mem[i];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [ROWS-1:0] inv_w, inv_r;
            logic            excl;
            inv_w = ~wl_write;
            inv_r = ~wl_read;
            excl  = ($countones(wl_write | wl_read) <= 1) && !((|wl_write) && (|wl_read));
            chk("compl_write", wl_writeN, inv_w);
            chk("compl_read", wl_readN, inv_r);
            chk("wl_exclusive", excl, 1);
        end
    end

    task automatic run_load(input logic [7:0] base, input int stall_row,
                            input int stall_len, input int abort_row);
        int fidx = 0, wcount = 0, ndone = 0, done_cyc = -1, stall_left = stall_len;
        bit accepted, aborted = 1'b0;
        cmd_op    = 1'b0;
        cmd_valid = 1'b1;
        in_valid  = 1'b1;
        in_data   = base;
        tick();
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (|wl_write) begin
                chk("ld_wl_order", wl_write, 32'(1) << wcount);
                chk("ld_bit_write", bit_write, 8'(base + 8'(wcount)));
                if (wcount == abort_row) begin
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    chk("abort_wl_write", wl_write, 0);
                    chk("abort_wl_read", wl_read, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_cmd_ready", cmd_ready, 1);
                    chk("abort_in_ready", in_ready, 0);
                    aborted = 1'b1;
                    break;
                end
                wcount++;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (in_ready && fidx == stall_row && stall_left > 0) begin
                in_valid = 1'b0;
                stall_left--;
                chk("stall_no_wl", wl_write, 0);
            end else begin
                in_valid = 1'b1;
            end
            in_data  = 8'(base + 8'(fidx));
            accepted = in_ready && in_valid;
            tick();
            if (accepted) fidx++;
            if (done_cyc > 0 && cyc >= done_cyc + 2) break;
        end
        in_valid = 1'b0;
        if (!aborted) begin
            chk("ld_row_count", wcount, ROWS);
            chk("ld_done_count", ndone, 1);
            chk("ld_done_cycle", done_cyc, 33 + stall_len);
            for (int i = 0; i < ROWS; i++)
                chk("ld_cell", mem[i], 8'(base + 8'(i)));
        end
    endtask

    task automatic run_readback(input logic [7:0] base, input int bp_row, input int bp_len);
        int rcount = 0, ndone = 0, done_cyc = -1, bp_left = bp_len;
        bit accepted;
        cmd_op    = 1'b1;
        cmd_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            accepted = 1'b0;
            if (|wl_read) chk("rb_wl_order", wl_read, 32'(1) << rcount);
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (out_valid) begin
                chk("rb_data", out_data, 8'(base + 8'(rcount)));
                if (rcount == bp_row && bp_left > 0) begin
                    out_ready = 1'b0;
                    bp_left--;
                    chk("rb_hold_wl", wl_read, 0);
                end else begin
                    out_ready = 1'b1;
                end
                accepted = out_ready;
            end else begin
                out_ready = 1'b1;
            end
            tick();
            if (accepted) rcount++;
            if (done_cyc > 0 && cyc >= done_cyc + 2) break;
        end
        chk("rb_frame_count", rcount, ROWS);
        chk("rb_done_count", ndone, 1);
        chk("rb_done_cycle", done_cyc, 33 + bp_len);
    endtask

    initial begin
        tick();
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();
        chk("rst_wl_write", wl_write, 0);
        chk("rst_wl_writeN", wl_writeN, 32'h0000_FFFF);
        chk("rst_wl_read", wl_read, 0);
        chk("rst_wl_readN", wl_readN, 32'h0000_FFFF);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_bit_write", bit_write, 0);
        chk("rst_out_data", out_data, 0);

        run_load(8'h00, -1, 0, -1);
        run_readback(8'h00, -1, 0);
        run_readback(8'h00, 3, 5);
        run_load(8'h30, 7, 4, -1);
        run_readback(8'h30, -1, 0);
        run_load(8'h50, -1, 0, 5);
        run_load(8'h60, -1, 0, -1);
        run_readback(8'h60, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/cfg_frame_loader.md
Name: cfg_frame_loader

Overview:
- Sequencing controller for one column-group of configuration SRAM cells: ROWS rows × COLS bits sharing COLS write bitlines and COLS tristate read bitlines.
- Accepts a command (LOAD or READBACK) and streams frames row by row over valid/ready handshakes.
- Drives complementary per-row write/read wordlines and the shared write bitlines; captures the read bitlines.
- Sits between the bitstream deserializer and the cell array in the FPGA fabric.

Parameters:
ROWS, 16, number of cell rows (word lines); must be >= 2
COLS, 8, bits per row (bitline width)
ROW_W, $clog2(ROWS), row index width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  1  0 = LOAD, 1 = READBACK
in_valid  in  1  load frame valid
in_data  in  COLS  load frame (one row)
in_ready  out  1  loader accepts frame
out_valid  out  1  readback frame valid
out_data  out  COLS  readback frame
out_ready  in  1  consumer accepts readback frame
wl_write  out  ROWS  per-row write enable (active high)
wl_writeN  out  ROWS  complement of wl_write
wl_read  out  ROWS  per-row read enable (active high)
wl_readN  out  ROWS  complement of wl_read
bit_write  out  COLS  shared write bitlines
bit_read  in  COLS  shared read bitlines (high-Z when no row is read)
busy  out  1  high when state != IDLE
done  out  1  one-cycle pulse at command completion

Behaviour:
- All outputs are registered. Reset values:
  - FSM IDLE; row = 0
  - wl_write = 0, wl_writeN = all 1s, wl_read = 0, wl_readN = all 1s
  - bit_write = 0, out_data = 0, out_valid = 0, in_ready = 0, busy = 0, done = 0
  - cmd_ready = 1 from the first cycle after reset
- Complement rule: wl_writeN == ~wl_write and wl_readN == ~wl_read in every cycle.
- Wordline exclusivity: at most one bit of wl_write|wl_read is high in any cycle, never both write and read.
- FSM states: IDLE, LD_WAIT, LD_WRITE, RB_READ, RB_HOLD, DONE.
- IDLE:
  - cmd_ready = 1.
  - cmd_valid & cmd_op = 0 -> LD_WAIT.
  - cmd_valid & cmd_op = 1 -> RB_READ.
  - row cleared to 0.
- LD_WAIT:
  - in_ready = 1.
  - On in_valid: latch in_data into bit_write, -> LD_WRITE.
  - bit_write holds its value otherwise.
- LD_WRITE (exactly 1 cycle):
  - wl_write[row] = 1, bit_write stable; the cell captures on the closing clock edge.
  - row == ROWS-1 -> DONE.
  - Otherwise row += 1 -> LD_WAIT.
  - Minimum 2 cycles per row; a full load with in_valid held high takes 2·ROWS cycles plus DONE.
- RB_READ (exactly 1 cycle):
  - wl_read[row] = 1.
  - bit_read is sampled into out_data at the closing edge -> RB_HOLD.
- RB_HOLD:
  - out_valid = 1, out_data stable.
  - On out_ready: row == ROWS-1 -> DONE, else row += 1 -> RB_READ.
  - Backpressure of any length is allowed; wordlines stay low while holding.
- DONE (1 cycle): done = 1, row := 0 -> IDLE.
- cmd_valid is ignored outside IDLE; no queuing.
- in_valid is ignored outside LD_WAIT, and out_ready outside RB_HOLD.
- Row counter is ROW_W bits. It never wraps; termination is at ROWS-1 only.
- Reset mid-operation: next cycle all wordlines are deasserted, out_valid = 0, FSM returns to IDLE. Cell contents are untouched by this block.

Decomposition:
- Package cfg_loader_pkg: state enum (IDLE..DONE), op constants OP_LOAD = 1'b0, OP_READBACK = 1'b1.
- One sub-module, cfg_row_decoder: registered one-hot decode of row + enable into the true/complement wordline pairs. Instantiated twice, once for write and once for read.

Test Plan:
- Reset then idle: after reset, all wl_* = 0, all wl_*N = 1, cmd_ready = 1, busy = 0, done = 0.
- LOAD, ROWS = 16, in_valid held high, frames 8'h00..8'h0F:
  - wl_write[i] pulses exactly once, in order.
  - bit_write = i during each pulse.
  - done pulses exactly 33 cycles after cmd accept.
  - Behavioural cell array holds row i = i.
- READBACK after the LOAD, out_ready always 1: out_data sequence 8'h00..8'h0F, one frame per 2 cycles, done once.
- Readback backpressure: out_ready low 5 cycles on row 3 -> out_valid and out_data = 8'h03 held, all wl_read = 0 during hold, then resume.
- Load stall: in_valid deasserted 4 cycles before row 7 -> no wl_write activity during stall; row 7 written with the correct data afterward.
- Reset asserted during LD_WRITE of row 5:
  - Next cycle all wordlines are low and FSM is IDLE.
  - A new LOAD restarts at row 0.
  - Check continuously: complement and exclusivity assertions hold every cycle.
